mux_arb_n: RTL and testbench
============================

# mux_arb_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects one source per cycle, either by an explicit select or by round-robin arbitration, and registers the chosen word. It generalises the team's 2-bit 2:1 combinational mux into the selection stage between multiple producers and a single consumer.

## Interface
- `W`, 2: data width per channel, in bits (≥1).
- `N`, 4: number of input channels (≥2).
- `SELW`, 2: select/source index width; the integrator sets it to ceil(log2(N)).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_data` in N*W: channel k occupies bits [k*W+W-1 : k*W].
- `in_valid` in N: per-channel valid.
- `in_ready` out N: per-channel ready. Combinational. At most one bit is high in any cycle.
- `mode` in 1: 0 = fixed select, 1 = round-robin.
- `sel` in SELW: channel index, used only when `mode`=0.
- `out_data` out W: registered selected word.
- `out_src` out SELW: registered index of the channel that supplied `out_data`.
- `out_valid` out 1: registered output valid.
- `out_ready` in 1: consumer ready.

## Operation
- `load_en` = !`out_valid` | `out_ready`. This makes the output register a single stage with no skid buffer. `in_ready` depends combinationally on `out_ready`.
- Grant, evaluated every cycle:
  - **`mode`=0:** grant channel `sel` if `in_valid[sel]`=1. If `sel` ≥ N, no channel is granted.
  - **`mode`=1:** grant the first channel with `in_valid`=1, scanning `last`+1, `last`+2, … modulo N and wrapping from N-1 to 0. `last` is the most recently accepted channel.
  - If no channel qualifies, there is no grant.
- `in_ready[g]` = `load_en` & grant_valid for the granted channel g. All other `in_ready` bits are 0.
- An input transfer occurs when `in_valid[g]` & `in_ready[g]`. On a transfer:
  - `out_data` ← channel g data, `out_src` ← g, `out_valid` ← 1.
  - `last` ← g, in both modes.
- If `load_en`=1 and there is no grant: `out_valid` ← 0. `out_data` and `out_src` hold their previous values.
- If `load_en`=0: all registers hold. Every `in_ready` is 0.
- An output transfer occurs on `out_valid` & `out_ready`. An input transfer in the same cycle refills the register, which sustains 1 word per cycle.
- Changes to `mode` or `sel` take effect in the same cycle's grant. They never disturb a word already held in the output register.
- Arbitration state: `last`, SELW bits, internal register.

## Timing
- Reset (`rst_n`=0, asynchronous): `out_valid`=0, `out_data`=0, `out_src`=0, `last`=N-1. With `last`=N-1, the first round-robin scan starts at channel 0.
- While in reset, every `in_ready` is 0, because grant is masked by reset.
- Reset asserted mid-transfer discards the held word. No partial state survives.
- Latency: an input accepted at edge t appears on `out_data`/`out_valid` immediately after edge t.
- Throughput: 1 transfer per cycle while `out_ready`=1 and some grant exists.
- Backpressure: while `out_valid`=1 and `out_ready`=0, the output is stable and no input is accepted.
- Round-robin fairness: with all N channels continuously valid and `out_ready`=1, each channel is granted exactly once in every N consecutive transfers.
- Simultaneous events:
  - Output drain and input fill in the same cycle: the new word wins and `out_valid` stays 1.
  - Drain with no grant: `out_valid` falls to 0 at the next edge.

## Test plan
- **Reset:** with W=2, N=4, `rst_n`=0 → `out_valid`=0, `out_data`=0, `out_src`=0, `in_ready`=4'b0000. Release reset, `mode`=1, `in_valid`=4'b1111, `out_ready`=1 → `out_src` sequence 0,1,2,3,0 on consecutive cycles.
- **Fixed select:** `mode`=0, `sel`=2, `in_data`={2'b11,2'b10,2'b01,2'b00}, `in_valid`=4'b0100 → `in_ready`=4'b0100, next cycle `out_data`=2'b10, `out_src`=2. Then `in_valid`=4'b1011 → `in_ready`=0000, and `out_valid` drops to 0 the following cycle.
- **Backpressure:** hold `out_ready`=0 with `out_valid`=1 and `out_data`=2'b01 for 3 cycles while inputs toggle → `out_data`, `out_src` and `out_valid` unchanged, `in_ready`=0000. Raise `out_ready` → a new word loads at the next edge.
- **Round-robin skip and wrap:** `last`=1, `in_valid`=4'b0001 → channel 0 is granted via wrap. Then `in_valid`=4'b1001 → channel 3 is granted, then channel 0 next.
- **Mode switch and asynchronous reset:** switch `mode` 1→0 mid-stream with `sel`=1 → the next grant is channel 1 regardless of `last`. Assert `rst_n`=0 between edges while `out_valid`=1 → outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, W-bit registered multiplexer with valid/ready handshakes.
//
// Each cycle one source is picked, either by an explicit index (mode=0) or by
// round-robin arbitration (mode=1). The picked word goes into a single output
// register that has no skid buffer. The register reloads whenever it is empty
// or being drained, so the block sustains one word per cycle.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_data    - N packed words; channel k is in_data[k*W +: W]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready (combinational, at most one bit high)
//   mode       - 0 = fixed select by sel, 1 = round-robin
//   sel        - channel index used when mode=0 (index >= N grants nothing)
//   out_data   - registered selected word
//   out_src    - registered index of the channel that supplied out_data
//   out_valid  - registered output valid
//   out_ready  - consumer ready
module mux_arb_n #(
    parameter int unsigned W    = 2,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    // last resets to N-1 so that the first round-robin scan begins at channel 0.
    localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

    logic [W-1:0]    out_data_r;
    logic [SELW-1:0] out_src_r;
    logic            out_valid_r;
    logic [SELW-1:0] last_r;

    logic            load_en_s;
    logic            grant_valid_s;
    logic [SELW-1:0] grant_idx_s;
    logic [SELW-1:0] cand_s;
    logic [W-1:0]    sel_data_s;

    // The register may take a new word when it is empty or being drained now.
    assign load_en_s = ~out_valid_r | out_ready;

    // Grant selection: explicit index in mode 0, rotating priority after last in mode 1.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        if (mode == 1'b0) begin
            if (32'(sel) < N) begin
                if (in_valid[sel]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = sel;
                end else begin
                    grant_valid_s = 1'b0;
                end
            end else begin
                grant_valid_s = 1'b0;
            end
        end else begin
            // Scan last+1, last+2, ... modulo N; the first valid channel wins.
            for (int unsigned i = 1; i <= N; i++) begin
                cand_s = SELW'((32'(last_r) + i) % N);
                if (!grant_valid_s && in_valid[cand_s]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = cand_s;
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // Data mux for the granted channel; one-hot match ORed across channels.
    always_comb begin
        sel_data_s = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sel_data_s = sel_data_s | (in_data[k*W +: W] & {W{SELW'(k) == grant_idx_s}});
        end
    end

    // Ready goes only to the granted channel, and never while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en_s && grant_valid_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_src_r   <= '0;
            out_valid_r <= 1'b0;
            last_r      <= LAST_RST;
        end else if (load_en_s) begin
            if (grant_valid_s) begin
                out_data_r  <= sel_data_s;
                out_src_r   <= grant_idx_s;
                out_valid_r <= 1'b1;
                last_r      <= grant_idx_s;
            end else begin
                // Nothing to load: drop valid, keep the stale word and source.
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;

    localparam int W    = 2;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_src;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state: contents of the output stage and the last accepted channel.
    bit              m_valid;
    logic [W-1:0]    m_data;
    logic [SELW-1:0] m_src;
    int              m_last;

    mux_arb_n #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = '0;
        m_last  = N - 1;
    endtask

    // Which channel the rules grant for the current inputs and model state.
    function automatic void model_grant(output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!gv && in_valid[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic step(input string tag);
        bit         gv;
        int         g;
        bit         le;
        logic [3:0] exp_rdy;
        #1;
        model_grant(gv, g);
        le      = !m_valid || out_ready;
        exp_rdy = (le && gv) ? 4'(1 << g) : 4'b0000;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (le) begin
            if (gv) begin
                m_data  = in_data[g*W +: W];
                m_src   = SELW'(g);
                m_valid = 1'b1;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".out_src"},   32'(out_src),   32'(m_src));
    endtask

    initial begin
        logic [W-1:0] saved;
        int           cnt [N];

        // Reset with every input active: outputs clear, nothing is ready.
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_data   = 8'($urandom);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        model_reset();
        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_src",   32'(out_src),   32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd0);

        // Release reset; round-robin over all-valid channels starts at 0.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom);
            step("rr_start");
            check("rr_start.seq", 32'(out_src), 32'(i % N));
        end

        // Fixed select of channel 2.
        mode     = 1'b0;
        sel      = 2'd2;
        in_data  = 8'b11_10_01_00;
        in_valid = 4'b0100;
        #1;
        check("fs.in_ready_const", 32'(in_ready), 32'b0100);
        step("fs1");
        check("fs1.data_const", 32'(out_data), 32'b10);
        check("fs1.src_const",  32'(out_src),  32'd2);
        in_valid = 4'b1011;
        step("fs2");
        check("fs2.valid_const", 32'(out_valid), 32'd0);

        // Backpressure: load channel 1 (data 01), then stall three cycles.
        sel      = 2'd1;
        in_valid = 4'b0010;
        step("bp_load");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'($urandom);
            in_data  = 8'($urandom);
            mode     = 1'($urandom);
            step("bp_hold");
            check("bp_hold.data_const",  32'(out_data),  32'b01);
            check("bp_hold.src_const",   32'(out_src),   32'd1);
            check("bp_hold.valid_const", 32'(out_valid), 32'd1);
        end
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 8'($urandom);
        saved     = in_data[1*W +: W];
        step("bp_release");
        check("bp_release.data", 32'(out_data), 32'(saved));

        // Round-robin skip and wrap, starting from last=1.
        mode     = 1'b1;
        in_valid = 4'b0001;
        step("wrap0");
        check("wrap0.src", 32'(out_src), 32'd0);
        in_valid = 4'b1001;
        step("skip3");
        check("skip3.src", 32'(out_src), 32'd3);
        step("back0");
        check("back0.src", 32'(out_src), 32'd0);

        // Fairness: each channel exactly twice in eight transfers.
        for (int c = 0; c < N; c++) cnt[c] = 0;
        in_valid = 4'b1111;
        for (int i = 0; i < 2 * N; i++) begin
            in_data = 8'($urandom);
            step("fair");
            cnt[out_src]++;
        end
        for (int c = 0; c < N; c++) check("fair.count", 32'(cnt[c]), 32'd2);

        // Mode switch mid-stream to fixed channel 1.
        mode = 1'b0;
        sel  = 2'd1;
        step("mode_sw");
        check("mode_sw.src", 32'(out_src), 32'd1);

        // Asynchronous reset between edges while holding a word.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.out_data",  32'(out_data),  32'd0);
        check("arst.out_src",   32'(out_src),   32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd0);
        mode = 1'b1;
        @(posedge clk);
        #1;
        check("arst.hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("arst_rr");
        check("arst_rr.src", 32'(out_src), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            sel       = SELW'($urandom);
            in_valid  = 4'($urandom);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
